display_axi_rd_arbiter: RTL and testbench

// Shares the single 64-bit AXI read master of the display subsystem between NUM_CHANNELS

---
 rtl/display_axi_rd_arbiter_pkg.sv | 12 +
 rtl/display_axi_rd_arbiter_if.sv | 45 ++++
 rtl/display_axi_rd_arbiter_order_fifo.sv | 53 +++++
 rtl/display_axi_rd_arbiter.sv | 150 +++++++++++++++
 tb/tb_display_axi_rd_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/display_axi_rd_arbiter_pkg.sv
// Shared AXI encodings and the AR-side state type for the display read arbiter.
package display_pkg;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_8B    = 3'd3;

    typedef enum logic {
        AR_IDLE  = 1'b0,
        AR_ISSUE = 1'b1
    } ar_state_t;

endpackage

// File: rtl/display_axi_rd_arbiter_if.sv
// Bus bundle between the per-layer readers (s_*) and the NoC read master (m_*).
interface display_axi_rd_arbiter_if #(
    parameter int unsigned NUM_CHANNELS = 3,
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 64
);
    logic [NUM_CHANNELS*ADDR_W-1:0] s_araddr;
    logic [NUM_CHANNELS*8-1:0]      s_arlen;
    logic [NUM_CHANNELS*3-1:0]      s_arsize;
    logic [NUM_CHANNELS*2-1:0]      s_arburst;
    logic [NUM_CHANNELS-1:0]        s_arvalid;
    logic [NUM_CHANNELS-1:0]        s_arready;
    logic [DATA_W-1:0]              s_rdata;
    logic [1:0]                     s_rresp;
    logic                           s_rlast;
    logic [NUM_CHANNELS-1:0]        s_rvalid;
    logic [NUM_CHANNELS-1:0]        s_rready;

    logic [ADDR_W-1:0]              m_araddr;
    logic [7:0]                     m_arlen;
    logic [2:0]                     m_arsize;
    logic [1:0]                     m_arburst;
    logic                           m_arvalid;
    logic                           m_arready;
    logic [DATA_W-1:0]              m_rdata;
    logic [1:0]                     m_rresp;
    logic                           m_rlast;
    logic                           m_rvalid;
    logic                           m_rready;

    modport master (
        input  s_araddr, s_arlen, s_arsize, s_arburst, s_arvalid, s_rready,
        input  m_arready, m_rdata, m_rresp, m_rlast, m_rvalid,
        output s_arready, s_rdata, s_rresp, s_rlast, s_rvalid,
        output m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready
    );

    modport slave (
        output s_araddr, s_arlen, s_arsize, s_arburst, s_arvalid, s_rready,
        output m_arready, m_rdata, m_rresp, m_rlast, m_rvalid,
        input  s_arready, s_rdata, s_rresp, s_rlast, s_rvalid,
        input  m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready
    );

endinterface

// File: rtl/display_axi_rd_arbiter_order_fifo.sv
// Order FIFO of granted channel indices; head is read combinationally for R routing.
module disp_rd_order_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == CNT_W'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];
    assign count   = cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/display_axi_rd_arbiter.sv
// Round-robin AR arbiter for the display read master with in-order R routing
// back to the requesting layer reader.
module display_axi_rd_arbiter
    import display_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS = 3,
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 64,
    parameter int unsigned MAX_OUTST    = 4
) (
    input  logic                           pixel_clk,
    input  logic                           rst_n,
    input  logic [NUM_CHANNELS-1:0]        ch_enable,
    display_axi_rd_arbiter_if.master       bus,
    output logic [$clog2(MAX_OUTST+1)-1:0] outstanding,
    output logic                           r_stray
);
    localparam int unsigned IDX_W = $clog2(NUM_CHANNELS);

    ar_state_t               state, state_nx;
    logic [IDX_W-1:0]        last_grant;
    logic [IDX_W-1:0]        winner;
    logic [IDX_W-1:0]        cand;
    logic [IDX_W-1:0]        head;
    logic                    found;
    logic [NUM_CHANNELS-1:0] req;
    logic [NUM_CHANNELS-1:0] grant;
    logic [NUM_CHANNELS-1:0] rvalid_route;
    logic                    rready_route;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    pop;
    logic [DATA_W-1:0]       rdata;

    logic [ADDR_W-1:0] addr_ch  [NUM_CHANNELS];
    logic [7:0]        len_ch   [NUM_CHANNELS];
    logic [2:0]        size_ch  [NUM_CHANNELS];
    logic [1:0]        burst_ch [NUM_CHANNELS];

    logic [ADDR_W-1:0] ar_addr_q;
    logic [7:0]        ar_len_q;
    logic [2:0]        ar_size_q;
    logic [1:0]        ar_burst_q;

    always_comb begin
        for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
            addr_ch[i]  = bus.s_araddr[i*ADDR_W +: ADDR_W];
            len_ch[i]   = bus.s_arlen[i*8 +: 8];
            size_ch[i]  = bus.s_arsize[i*3 +: 3];
            burst_ch[i] = bus.s_arburst[i*2 +: 2];
        end
    end

    // Scan starts one past the previous winner so every enabled reader gets a turn.
    always_comb begin
        req    = bus.s_arvalid & ch_enable;
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int unsigned i = 1; i <= NUM_CHANNELS; i++) begin
            cand = IDX_W'((32'(last_grant) + i) % NUM_CHANNELS);
            if (!found && req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        state_nx = state;
        grant    = '0;
        unique case (state)
            AR_IDLE: begin
                if (found && !fifo_full) begin
                    grant[winner] = 1'b1;
                    state_nx      = AR_ISSUE;
                end
            end
            AR_ISSUE: begin
                if (bus.m_arready) state_nx = AR_IDLE;
            end
            default: state_nx = AR_IDLE;
        endcase
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= AR_IDLE;
            last_grant <= IDX_W'(NUM_CHANNELS - 1);
            ar_addr_q  <= '0;
            ar_len_q   <= '0;
            ar_size_q  <= '0;
            ar_burst_q <= '0;
        end else begin
            state <= state_nx;
            if (|grant) begin
                last_grant <= winner;
                ar_addr_q  <= addr_ch[winner];
                ar_len_q   <= len_ch[winner];
                ar_size_q  <= size_ch[winner];
                ar_burst_q <= burst_ch[winner];
            end
        end
    end

    assign bus.s_arready = grant;
    assign bus.m_arvalid = (state == AR_ISSUE);
    assign bus.m_araddr  = ar_addr_q;
    assign bus.m_arlen   = ar_len_q;
    assign bus.m_arsize  = ar_size_q;
    assign bus.m_arburst = ar_burst_q;

    disp_rd_order_fifo #(
        .DEPTH (MAX_OUTST),
        .WIDTH (IDX_W)
    ) u_order_fifo (
        .clk       (pixel_clk),
        .rst_n     (rst_n),
        .push      (|grant),
        .push_data (winner),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (outstanding)
    );

    always_comb begin
        rvalid_route = '0;
        rready_route = 1'b0;
        if (!fifo_empty) begin
            rvalid_route[head] = bus.m_rvalid;
            rready_route       = bus.s_rready[head];
        end
    end

    assign pop           = bus.m_rvalid && rready_route && bus.m_rlast;
    assign rdata         = bus.m_rdata;
    assign bus.s_rdata   = rdata;
    assign bus.s_rresp   = bus.m_rresp;
    assign bus.s_rlast   = bus.m_rlast;
    assign bus.s_rvalid  = rvalid_route;
    assign bus.m_rready  = rready_route;

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n)                         r_stray <= 1'b0;
        else if (fifo_empty && bus.m_rvalid) r_stray <= 1'b1;
    end

endmodule

// File: tb/tb_display_axi_rd_arbiter.sv
// Directed self-checking bench for display_axi_rd_arbiter with hand-derived expectations.
module tb_display_axi_rd_arbiter;
    import display_pkg::*;

    localparam int unsigned NCH = 3;
    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 64;
    localparam int unsigned MO  = 4;

    logic           pixel_clk = 1'b0;
    logic           rst_n     = 1'b0;
    logic [NCH-1:0] ch_enable;
    logic [2:0]     outstanding;
    logic           r_stray;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    display_axi_rd_arbiter_if #(.NUM_CHANNELS(NCH), .ADDR_W(AW), .DATA_W(DW)) bus ();

    display_axi_rd_arbiter #(
        .NUM_CHANNELS (NCH),
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .MAX_OUTST    (MO)
    ) dut (
        .pixel_clk   (pixel_clk),
        .rst_n       (rst_n),
        .ch_enable   (ch_enable),
        .bus         (bus),
        .outstanding (outstanding),
        .r_stray     (r_stray)
    );

    always #5 pixel_clk = ~pixel_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Inputs change 1ns after the edge; checks run 2ns later, well clear of both edges.
    task automatic cyc();
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic clear_inputs();
        ch_enable     = '0;
        bus.s_araddr  = '0;
        bus.s_arlen   = '0;
        bus.s_arsize  = '0;
        bus.s_arburst = '0;
        bus.s_arvalid = '0;
        bus.s_rready  = '0;
        bus.m_arready = 1'b0;
        bus.m_rdata   = '0;
        bus.m_rresp   = '0;
        bus.m_rlast   = 1'b0;
        bus.m_rvalid  = 1'b0;
    endtask

    task automatic set_ch(input int unsigned ch, input logic [31:0] addr, input logic [7:0] len);
        bus.s_araddr[ch*AW +: AW] = addr;
        bus.s_arlen[ch*8 +: 8]    = len;
        bus.s_arsize[ch*3 +: 3]   = SIZE_8B;
        bus.s_arburst[ch*2 +: 2]  = BURST_INCR;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (3) @(posedge pixel_clk);
        #1;
        rst_n = 1'b1;
    endtask

    int unsigned order [6] = '{0, 1, 2, 0, 1, 2};

    initial begin
        clear_inputs();
        do_reset();

        // reset state
        settle();
        check("rst_arready", bus.s_arready, 0);
        check("rst_marvalid", bus.m_arvalid, 0);
        check("rst_maraddr", bus.m_araddr, 0);
        check("rst_outst", outstanding, 0);
        check("rst_stray", r_stray, 0);
        check("rst_mrready", bus.m_rready, 0);
        check("rst_srvalid", bus.s_rvalid, 0);

        // 1: single 8-beat burst to ch0
        cyc();
        ch_enable = 3'b111;
        set_ch(0, 32'h1000, 8'd7);
        bus.s_arvalid = 3'b001;
        bus.m_arready = 1'b1;
        settle();
        check("t1_grant", bus.s_arready, 3'b001);
        check("t1_marvalid0", bus.m_arvalid, 0);
        cyc();
        bus.s_arvalid = '0;
        settle();
        check("t1_marvalid", bus.m_arvalid, 1);
        check("t1_maraddr", bus.m_araddr, 32'h1000);
        check("t1_marlen", bus.m_arlen, 7);
        check("t1_marsize", bus.m_arsize, 3);
        check("t1_marburst", bus.m_arburst, 1);
        check("t1_outst1", outstanding, 1);
        for (int b = 0; b < 8; b++) begin
            cyc();
            bus.s_rready = 3'b111;
            bus.m_rvalid = 1'b1;
            bus.m_rdata  = 64'h100 + 64'(b);
            bus.m_rlast  = (b == 7);
            settle();
            check("t1_srvalid", bus.s_rvalid, 3'b001);
            check("t1_srdata", bus.s_rdata, 64'h100 + 64'(b));
            check("t1_outst_beat", outstanding, 1);
        end
        cyc();
        bus.m_rvalid = 1'b0;
        bus.m_rlast  = 1'b0;
        settle();
        check("t1_outst0", outstanding, 0);
        check("t1_stray", r_stray, 0);

        // 2: three readers requesting continuously, single-beat bursts drained at once
        do_reset();
        cyc();
        ch_enable = 3'b111;
        set_ch(0, 32'h100, 8'd0);
        set_ch(1, 32'h200, 8'd0);
        set_ch(2, 32'h300, 8'd0);
        bus.s_arvalid = 3'b111;
        bus.m_arready = 1'b1;
        bus.s_rready  = 3'b111;
        bus.m_rvalid  = 1'b1;
        bus.m_rlast   = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (k != 0) cyc();
            settle();
            if (k % 2 == 0) begin
                check("t2_grant", bus.s_arready, 64'(1) << order[k/2]);
                check("t2_idle", bus.m_arvalid, 0);
            end else begin
                check("t2_nogrant", bus.s_arready, 0);
                check("t2_issue", bus.m_arvalid, 1);
                check("t2_addr", bus.m_araddr, 64'(32'h100 * (order[k/2] + 1)));
            end
        end

        // 3: four outstanding bursts block the fifth until an rlast
        do_reset();
        cyc();
        ch_enable = 3'b111;
        set_ch(0, 32'h4000, 8'd0);
        bus.s_arvalid = 3'b001;
        bus.m_arready = 1'b1;
        for (int k = 0; k < 13; k++) begin
            if (k != 0) cyc();
            if (k == 10) begin
                bus.m_rvalid = 1'b1;
                bus.m_rlast  = 1'b1;
                bus.s_rready = 3'b001;
            end
            if (k == 11) begin
                bus.m_rvalid = 1'b0;
                bus.m_rlast  = 1'b0;
            end
            if (k == 12) bus.s_arvalid = '0;
            settle();
            if (k < 8 && k % 2 == 0) check("t3_grant", bus.s_arready, 3'b001);
            if (k == 7)  check("t3_full", outstanding, 4);
            if (k == 8 || k == 9) check("t3_blocked", bus.s_arready, 0);
            if (k == 10) begin
                check("t3_blocked_pop", bus.s_arready, 0);
                check("t3_mrready", bus.m_rready, 1);
            end
            if (k == 11) begin
                check("t3_regrant", bus.s_arready, 3'b001);
                check("t3_outst3", outstanding, 3);
            end
            if (k == 12) begin
                check("t3_outst4", outstanding, 4);
                check("t3_issue", bus.m_arvalid, 1);
            end
        end

        // 4: ch1 at head back-pressures; other readers' ready must not leak through
        do_reset();
        cyc();
        ch_enable = 3'b111;
        set_ch(1, 32'h2000, 8'd0);
        bus.s_arvalid = 3'b010;
        bus.m_arready = 1'b1;
        settle();
        check("t4_grant", bus.s_arready, 3'b010);
        cyc();
        bus.s_arvalid = '0;
        settle();
        check("t4_addr", bus.m_araddr, 32'h2000);
        for (int k = 0; k < 3; k++) begin
            cyc();
            bus.m_rvalid = 1'b1;
            bus.m_rdata  = 64'hDEADBEEF_CAFEF00D;
            bus.m_rresp  = 2'b10;
            bus.m_rlast  = 1'b1;
            bus.s_rready = 3'b101;
            settle();
            check("t4_stall_mrready", bus.m_rready, 0);
            check("t4_stall_srvalid", bus.s_rvalid, 3'b010);
            check("t4_stall_outst", outstanding, 1);
        end
        cyc();
        bus.s_rready = 3'b010;
        settle();
        check("t4_mrready", bus.m_rready, 1);
        check("t4_rdata", bus.s_rdata, 64'hDEADBEEF_CAFEF00D);
        check("t4_rresp", bus.s_rresp, 2'b10);
        check("t4_rlast", bus.s_rlast, 1);
        cyc();
        bus.m_rvalid = 1'b0;
        bus.s_rready = '0;
        settle();
        check("t4_outst0", outstanding, 0);
        check("t4_nostray", r_stray, 0);

        // 5: R beat with nothing outstanding
        cyc();
        bus.m_rvalid = 1'b1;
        bus.m_rlast  = 1'b0;
        bus.s_rready = 3'b111;
        settle();
        check("t5_mrready", bus.m_rready, 0);
        check("t5_srvalid", bus.s_rvalid, 0);
        check("t5_stray_pre", r_stray, 0);
        cyc();
        bus.m_rvalid = 1'b0;
        settle();
        check("t5_stray", r_stray, 1);
        repeat (3) cyc();
        settle();
        check("t5_stray_sticky", r_stray, 1);

        // 6: reset while holding an AR with two bursts outstanding
        do_reset();
        settle();
        check("t6_stray_clr", r_stray, 0);
        cyc();
        ch_enable = 3'b111;
        set_ch(0, 32'h3000, 8'd3);
        set_ch(2, 32'h5000, 8'd3);
        bus.s_arvalid = 3'b101;
        bus.m_arready = 1'b1;
        settle();
        check("t6_grant0", bus.s_arready, 3'b001);
        cyc();
        bus.s_arvalid = 3'b100;
        cyc();
        bus.m_arready = 1'b0;
        settle();
        check("t6_grant2", bus.s_arready, 3'b100);
        cyc();
        bus.s_arvalid = '0;
        settle();
        check("t6_hold_valid", bus.m_arvalid, 1);
        check("t6_hold_addr", bus.m_araddr, 32'h5000);
        check("t6_outst2", outstanding, 2);
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", bus.m_arvalid, 0);
        check("t6_rst_addr", bus.m_araddr, 0);
        check("t6_rst_outst", outstanding, 0);
        check("t6_rst_arready", bus.s_arready, 0);
        check("t6_rst_mrready", bus.m_rready, 0);
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        bus.m_rvalid = 1'b1;
        bus.m_rlast  = 1'b1;
        bus.s_rready = 3'b111;
        settle();
        check("t6_late_srvalid", bus.s_rvalid, 0);
        check("t6_late_mrready", bus.m_rready, 0);
        cyc();
        bus.m_rvalid = 1'b0;
        bus.m_rlast  = 1'b0;
        bus.s_arvalid = 3'b111;
        settle();
        check("t6_late_stray", r_stray, 1);
        check("t6_first_grant", bus.s_arready, 3'b001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
